zero_one_scheduler: RTL
=======================

ZERO_ONE_SCHEDULER -- requirements
Module: zero_one_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of serial input channels (power of two, 2..8).
REQ-002 The block SHALL have parameter CW, default 8, giving the hit-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NCH bits: per-channel request; a set bit means a serial bit is offered.
REQ-006 The block SHALL have port A, input, NCH bits: per-channel offered serial bit, valid when the matching req bit is set.
REQ-007 The block SHALL have port gnt, output, NCH bits: combinational one-hot grant; a set bit means that channel's bit is consumed this cycle.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: a registered "01" detection event is pending.
REQ-009 The block SHALL have port evt_ch, output, log2(NCH) bits: the channel index of the pending event.
REQ-010 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the event when evt_valid and evt_ready are both high.
REQ-011 The block SHALL have port cnt_sel, input, log2(NCH) bits: selects which hit counter drives cnt_out.
REQ-012 The block SHALL have port cnt_out, output, CW bits: combinational read of the hit counter selected by cnt_sel.

Function
REQ-013 The block SHALL time-share one "01" detection engine across the NCH channels, granting at most one channel per cycle.
REQ-014 Arbitration SHALL be round-robin: the winner is the lowest requesting index at or above pointer ptr, wrapping to index 0.
REQ-015 After any grant, ptr SHALL become (winner+1) mod NCH; with no grant, ptr SHALL hold.
REQ-016 gnt SHALL be all-zero while stalled, where stalled is defined as evt_valid=1 and evt_ready=0 (back-pressure).
REQ-017 Each channel SHALL hold a private state: S_IDLE (no bit seen), S_ZERO (last consumed bit 0), or S_ONE (last consumed bit 1).
REQ-018 On a grant, the channel state SHALL move to S_ZERO if A=0, or to S_ONE if A=1; non-granted channels SHALL hold their state.
REQ-019 A hit SHALL be defined as a granted bit with A=1 while that channel's state is S_ZERO.
REQ-020 Event register updates SHALL follow this priority: a hit loads evt_valid=1 and evt_ch=winner; else a handshake clears evt_valid; else the register holds.
REQ-021 A hit concurrent with an accepted event SHALL replace the event, so evt_valid stays 1 with the new evt_ch and no bubble cycle occurs.
REQ-022 On a hit, the channel's counter SHALL increment by 1, saturating at 2^CW-1.
REQ-023 Hit detection latency SHALL be exactly 1 cycle from the grant edge to evt_valid=1; at most one event is buffered.

Reset
REQ-024 When rst=1 at a clk edge, ptr SHALL become 0, all channel states SHALL become S_IDLE, evt_valid SHALL become 0, evt_ch SHALL become 0, and all counters SHALL become 0.
REQ-025 While rst=1, gnt SHALL be all-zero.
REQ-026 A reset asserted mid-operation SHALL discard any pending event without a handshake, and S_IDLE SHALL block detection until a 0 is consumed.

Configuration
REQ-027 Macro ZOS_HIT_COUNT_EN, when defined, SHALL compile in the NCH saturating hit counters and the cnt_out read mux.
REQ-028 Without ZOS_HIT_COUNT_EN, no counter flops SHALL exist, cnt_out SHALL be tied to 0, and cnt_sel SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-029 Scenario 1: reset, then ch0 only, offering bits 0,1 with evt_ready=1 -> gnt=0001 on both cycles; evt_valid=1 with evt_ch=0 one cycle after the second grant; cnt_out(sel 0)=1.
REQ-030 Scenario 2: all 4 req high for 8 cycles, evt_ready=1 -> gnt sequence is 0001,0010,0100,1000, repeating.
REQ-031 Scenario 3: ch1 reaches S_ZERO, then hits with evt_ready=0 -> evt_valid=1 and evt_ch=1 persist, gnt=0 while held; evt_ready=1 for one cycle -> evt_valid=0 the next cycle, and grants resume.
REQ-032 Scenario 4: an accepted event on ch2 coinciding with a hit on ch3 -> evt_valid stays 1 and evt_ch=3 the next cycle.
REQ-033 Scenario 5: with CW=8, 300 hits on ch0 -> cnt_out=255; also, after reset, a first bit 1 produces no event.
REQ-034 Scenario 6: rst=1 while an event is pending -> evt_valid=0 and cnt_out=0 the next cycle; with ZOS_HIT_COUNT_EN undefined, cnt_out=0 throughout.

Source files
------------

// File: rtl/zero_one_scheduler.sv
// zero_one_scheduler: round-robin time-shared "01" detector over NCH serial channels.
// Each channel keeps its own last-bit state. A grant consumes one offered bit, and a
// 0 followed by a 1 on the same channel raises a one-deep registered event.
// Optional feature macro: ZOS_HIT_COUNT_EN adds per-channel saturating hit counters
// and the cnt_out read mux. Without it, cnt_out is tied to 0.

// Per-channel state tracker, plus an optional saturating hit counter.
module zos_lane #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic          a,
  output logic          hit,
  output logic [CW-1:0] cnt
);
  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ONE} st_t;
  st_t st;

  // A 1 only counts as a hit when the previously consumed bit was 0.
  // S_IDLE therefore swallows a leading 1.
  assign hit = gnt & a & (st == S_ZERO);

  // Remember the last consumed bit; non-granted cycles hold.
  always_ff @(posedge clk) begin
    if (rst)      st <= S_IDLE;
    else if (gnt) st <= a ? S_ONE : S_ZERO;
  end

`ifdef ZOS_HIT_COUNT_EN
  // Hit counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (hit && cnt != '1) cnt <= cnt + CW'(1);
  end
`else
  assign cnt = '0;
`endif
endmodule

module zero_one_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  localparam int LW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] A,
  output logic [NCH-1:0] gnt,
  output logic           evt_valid,
  output logic [LW-1:0]  evt_ch,
  input  logic           evt_ready,
  input  logic [LW-1:0]  cnt_sel,
  output logic [CW-1:0]  cnt_out
);
  typedef struct packed {
    logic          vld;
    logic [LW-1:0] ch;
  } evt_t;

  evt_t                   evt_q;
  logic [LW-1:0]          ptr;
  logic [LW-1:0]          win;
  logic                   any_req;
  logic                   grant_ok;
  logic                   stall;
  logic [NCH-1:0]         gnt_w;
  logic [NCH-1:0]         hit;
  logic [NCH-1:0][CW-1:0] lane_cnt;

  assign evt_valid = evt_q.vld;
  assign evt_ch    = evt_q.ch;
  assign stall     = evt_q.vld & ~evt_ready;
  assign grant_ok  = any_req & ~stall & ~rst;
  assign gnt       = gnt_w;

  // Round-robin search starting at ptr.
  // NCH is a power of two, so LW-bit addition wraps for free.
  always_comb begin
    logic [LW-1:0] idx;
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + LW'(i);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // One-hot grant is suppressed during reset and back-pressure.
  always_comb begin
    gnt_w = '0;
    if (grant_ok) gnt_w[win] = 1'b1;
  end

  zos_lane #(.CW(CW)) u_lane [NCH-1:0] (
    .clk (clk),
    .rst (rst),
    .gnt (gnt_w),
    .a   (A),
    .hit (hit),
    .cnt (lane_cnt)
  );

  // Pointer moves past the winner on every grant; otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst)           ptr <= '0;
    else if (grant_ok) ptr <= win + LW'(1);
  end

  // Event buffer: a new hit wins over a handshake, so an accept and a new hit
  // in the same cycle swap the event in place with no bubble.
  always_ff @(posedge clk) begin
    if (rst)                            evt_q <= '0;
    else if (|hit)                      evt_q <= '{vld: 1'b1, ch: win};
    else if (evt_q.vld && evt_ready)    evt_q.vld <= 1'b0;
  end

`ifdef ZOS_HIT_COUNT_EN
  assign cnt_out = lane_cnt[cnt_sel];
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, lane_cnt};
  assign cnt_out    = '0;
`endif
endmodule
